// File: rtl/md_stall_ctrl_pkg.sv
// md_stall_ctrl_pkg: shared state encodings and default constants for the D->E stall controller.
package md_stall_ctrl_pkg;
    typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_e;
    localparam int MD_MULT_CYC = 5;
    localparam int MD_DIV_CYC = 10;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/md_stall_ctrl_if.sv
// md_stall_ctrl_if: D/E hazard inputs and stall/bubble outputs between pipeline and stall controller.
interface md_stall_ctrl_if;
    logic       d_md_use;
    logic       d_rs_use;
    logic       d_rt_use;
    logic [4:0] d_rs_addr;
    logic [4:0] d_rt_addr;
    logic       e_load;
    logic [4:0] e_wr_addr;
    logic       e_md_start;
    logic       e_md_is_div;
    logic       stall_fd;
    logic       flush_de;
    logic       md_busy;
    logic       md_done;
    modport master (
        output d_md_use, d_rs_use, d_rt_use, d_rs_addr, d_rt_addr,
        output e_load, e_wr_addr, e_md_start, e_md_is_div,
        input  stall_fd, flush_de, md_busy, md_done
    );
    modport slave (
        input  d_md_use, d_rs_use, d_rt_use, d_rs_addr, d_rt_addr,
        input  e_load, e_wr_addr, e_md_start, e_md_is_div,
        output stall_fd, flush_de, md_busy, md_done
    );
endinterface

// File: rtl/md_stall_ctrl_md_busy_fsm.sv
// md_busy_fsm: mult/div busy state machine; counts down the remaining busy cycles after the start cycle.
module md_busy_fsm
    import md_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYC,
    parameter int DIV_CYCLES  = MD_DIV_CYC,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy_q,
    output logic done
);
    if (MULT_CYCLES < 1 || DIV_CYCLES < 1 || MULT_CYCLES >= (1 << CNT_W) || DIV_CYCLES >= (1 << CNT_W)) begin : g_bad_cfg
        $error("md_busy_fsm: cycle counts must be in 1 .. 2**CNT_W-1");
    end
    localparam logic [CNT_W-1:0] MULT_C = MULT_CYCLES[CNT_W-1:0];
    localparam logic [CNT_W-1:0] DIV_C  = DIV_CYCLES[CNT_W-1:0];
    localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] sel;
    logic             launch;
    logic             last;
    always_comb begin
        sel     = is_div ? DIV_C : MULT_C;
        // A one-cycle op finishes in its start cycle and never leaves IDLE.
        launch  = state_q == MD_IDLE && start && sel != ONE;
        last    = state_q == MD_BUSY && cnt_q == ONE;
        done    = !reset && (last || (state_q == MD_IDLE && start && sel == ONE));
        state_d = (reset || last) ? MD_IDLE : launch ? MD_BUSY : state_q;
        cnt_d   = (reset || last) ? '0 : launch ? sel - ONE : state_q == MD_BUSY ? cnt_q - ONE : cnt_q;
    end
    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end
    assign busy_q = state_q == MD_BUSY;
endmodule

// File: rtl/md_stall_ctrl.sv
// md_stall_ctrl: D->E stall/bubble control for mult/div occupancy and load-use hazards.
// Optional STALL_PERF_EN adds a 32-bit stall-cycle counter port.
module md_stall_ctrl
    import md_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYC,
    parameter int DIV_CYCLES  = MD_DIV_CYC,
    parameter int CNT_W       = 4
) (
    input  logic         clk,
    input  logic         reset,
    md_stall_ctrl_if.slave bus
`ifdef STALL_PERF_EN
    ,
    output logic [31:0]  stall_cnt
`endif
);
    logic busy_q;
    logic done;
    logic md_busy;
    logic md_hazard;
    logic ld_hazard;
    logic stall;
    md_busy_fsm #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_fsm (
        .clk    (clk),
        .reset  (reset),
        .start  (bus.e_md_start),
        .is_div (bus.e_md_is_div),
        .busy_q (busy_q),
        .done   (done)
    );
    always_comb begin
        md_busy   = !reset && (busy_q || bus.e_md_start);
        md_hazard = bus.d_md_use && md_busy;
        ld_hazard = bus.e_load && bus.e_wr_addr != REG_ZERO &&
                    ((bus.d_rs_use && bus.d_rs_addr == bus.e_wr_addr) ||
                     (bus.d_rt_use && bus.d_rt_addr == bus.e_wr_addr));
        stall     = !reset && (md_hazard || ld_hazard);
    end
    assign bus.stall_fd = stall;
    assign bus.flush_de = stall;
    assign bus.md_busy  = md_busy;
    assign bus.md_done  = done;
`ifdef STALL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    always_comb stall_cnt_d = reset ? 32'd0 : stall_cnt_q + {31'd0, stall};
    always_ff @(posedge clk) stall_cnt_q <= stall_cnt_d;
    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_md_stall_ctrl.sv
// tb_md_stall_ctrl: directed vector bench for md_stall_ctrl (default 5/10 cycle mult/div).
module tb_md_stall_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    md_stall_ctrl_if bus ();
`ifdef STALL_PERF_EN
    logic [31:0] stall_cnt;
`endif
    md_stall_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef STALL_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, md, rsu, rtu;
        logic [4:0] rs, rt;
        logic       ld;
        logic [4:0] wr;
        logic       st, dv;
        logic       x_stall, x_busy, x_done;
    } vec_t;

    function automatic vec_t mk(input logic rst, md, rsu, rtu, input logic [4:0] rs, rt,
                                input logic ld, input logic [4:0] wr, input logic st, dv,
                                input logic xs, xb, xd);
        vec_t v;
        v.rst = rst; v.md = md; v.rsu = rsu; v.rtu = rtu; v.rs = rs; v.rt = rt;
        v.ld = ld; v.wr = wr; v.st = st; v.dv = dv;
        v.x_stall = xs; v.x_busy = xb; v.x_done = xd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input string nm);
        @(negedge clk);
        reset = v.rst;
        bus.d_md_use = v.md; bus.d_rs_use = v.rsu; bus.d_rt_use = v.rtu;
        bus.d_rs_addr = v.rs; bus.d_rt_addr = v.rt;
        bus.e_load = v.ld; bus.e_wr_addr = v.wr;
        bus.e_md_start = v.st; bus.e_md_is_div = v.dv;
        #1;
        chk({nm, " stall_fd"}, bus.stall_fd, v.x_stall);
        chk({nm, " flush_de"}, bus.flush_de, v.x_stall);
        chk({nm, " md_busy"}, bus.md_busy, v.x_busy);
        chk({nm, " md_done"}, bus.md_done, v.x_done);
    endtask

    vec_t tbl[12];

    initial begin
        reset = 1'b1;
        bus.d_md_use = 0; bus.d_rs_use = 0; bus.d_rt_use = 0;
        bus.d_rs_addr = 0; bus.d_rt_addr = 0; bus.e_load = 0; bus.e_wr_addr = 0;
        bus.e_md_start = 0; bus.e_md_is_div = 0;
        // reset forces outputs low even with hazards present
        run(mk(1, 1, 1, 0, 8, 0, 1, 8, 1, 1, 0, 0, 0), "reset_hold");
        run(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "reset_idle");

        // mult in E with mfhi in D, then load-use patterns
        tbl[0]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0);
        tbl[1]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        tbl[2]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        tbl[3]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        tbl[4]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 1, 1, 8, 1, 1, 8, 0, 0, 1, 0, 0);
        tbl[7]  = mk(0, 0, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 0, 1, 1, 3, 9, 1, 9, 0, 0, 1, 0, 0);
        tbl[10] = mk(0, 0, 0, 1, 9, 3, 1, 9, 0, 0, 0, 0, 0);
        tbl[11] = mk(0, 0, 1, 1, 4, 5, 1, 6, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) run(tbl[i], $sformatf("vec%0d", i));

        // div in E, ALU op in D (no stall), then mflo stalls through cycle 10
        run(mk(0, 0, 1, 1, 2, 3, 0, 0, 1, 1, 0, 1, 0), "div_alu");
        for (int c = 2; c <= 10; c++)
            run(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, c == 10), $sformatf("div_mflo_c%0d", c));
        run(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "div_release");

        // load-use and div-busy overlap: one stall per cycle, ends with div
        run(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0), "mix_start");
        run(mk(0, 1, 1, 0, 8, 0, 1, 8, 0, 0, 1, 1, 0), "mix_both");
        for (int c = 3; c <= 10; c++)
            run(mk(0, 1, 1, 0, 8, 0, 0, 0, 0, 0, 1, 1, c == 10), $sformatf("mix_c%0d", c));
        run(mk(0, 1, 1, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0), "mix_release");

        // reset in cycle 3 of a div abandons it without md_done
        run(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0), "rst_div_c1");
        run(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), "rst_div_c2");
        run(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_div_c3");
        for (int c = 0; c < 3; c++)
            run(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), $sformatf("rst_after%0d", c));
        for (int c = 1; c <= 5; c++)
            run(mk(0, 1, 0, 0, 0, 0, 0, 0, c == 1, 0, 1, 1, c == 5), $sformatf("mult_after_rst_c%0d", c));
        run(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "mult_after_rst_end");

`ifdef STALL_PERF_EN
        run(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "perf_rst");
        for (int c = 1; c <= 10; c++)
            run(mk(0, 1, 0, 0, 0, 0, 0, 0, c == 1, 1, 1, 1, c == 10), $sformatf("perf_div_c%0d", c));
        run(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "perf_idle");
        checks++;
        if (stall_cnt !== 32'd10) begin
            errors++;
            $display("FAIL stall_cnt_div: got %0d expected 10", stall_cnt);
        end
        @(negedge clk);
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1 release dut.stall_cnt_q;
        run(mk(0, 0, 1, 0, 8, 0, 1, 8, 0, 0, 1, 0, 0), "wrap_s1");
        run(mk(0, 0, 1, 0, 8, 0, 1, 8, 0, 0, 1, 0, 0), "wrap_s2");
        run(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "wrap_idle");
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL stall_cnt_wrap: got %h expected 00000000", stall_cnt);
        end
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
